// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg
// Shared definitions for the instruction/data Wishbone arbiter:
//   - arb_state_e : arbiter FSM state encoding (idle, I owns bus, D owns bus)
//   - GNT_*       : grant codes presented on gnt_o
//   - SEL_ALL     : byte-select pattern used for instruction fetches
//   - tmo_width() : stall-timeout counter width, clamped to 8..16 bits
package riscv_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam logic [3:0] SEL_ALL  = 4'hF;

    // Bits needed to count up to 'cycles', never narrower than 8 or wider than 16.
    function automatic int tmo_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8) begin
            w = 8;
        end
        if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/riscv_wb_rr_arb.sv
// riscv_wb_rr_arb
// Two-input round-robin picker.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req[1:0]      : request vector, bit 0 = instruction master, bit 1 = data master
//   advance       : the grant presented this cycle is being taken
//   gnt[1:0]      : one-hot grant (combinational from req and the pointer)
// The pointer resets to favour the data master. Whenever a grant is taken the
// pointer moves to favour the other master, so a tie always goes to the
// master that did not win last time.
module riscv_wb_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1: data master wins a tie, 0: instruction master wins a tie
    logic ptr_d_r;

    // Pick a single winner from the request vector.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_d_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Move the pointer away from whoever was just granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_d_r <= 1'b1;
        end else if (advance) begin
            if (gnt[1]) begin
                ptr_d_r <= 1'b0;
            end else if (gnt[0]) begin
                ptr_d_r <= 1'b1;
            end else begin
                ptr_d_r <= ptr_d_r;
            end
        end else begin
            ptr_d_r <= ptr_d_r;
        end
    end

endmodule

// File: rtl/riscv_wb_arb.sv
// riscv_wb_arb
// Wishbone B3 classic arbiter: the core's instruction bus (i_*) and data bus
// (d_*) share one master port (m_*). Round-robin per transfer; the grant is
// held until the slave terminates the transfer (ack/err) or the owner drops cyc.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   i_cyc/stb/adr_i         : instruction master request (read only)
//   i_dat/ack/err_o         : instruction master response
//   d_cyc/stb/we/sel/adr/dat_i : data master request
//   d_dat/ack/err_o         : data master response
//   m_cyc/stb/we/sel/adr/dat_o : shared bus request
//   m_dat/ack/err_i         : shared bus response
//   gnt_o                   : current owner, 00 none, 01 I, 10 D
// Optional build macro WB_ARB_TIMEOUT_EN: a stall counter errors out a
// transfer the slave has not answered after TIMEOUT_CYCLES strobed cycles.
module riscv_wb_arb
    import riscv_wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_cyc_i,
    input  logic              i_stb_i,
    input  logic [ADDR_W-1:0] i_adr_i,
    output logic [DATA_W-1:0] i_dat_o,
    output logic              i_ack_o,
    output logic              i_err_o,
    input  logic              d_cyc_i,
    input  logic              d_stb_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [ADDR_W-1:0] d_adr_i,
    input  logic [DATA_W-1:0] d_dat_i,
    output logic [DATA_W-1:0] d_dat_o,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [3:0]        m_sel_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic [DATA_W-1:0] m_dat_o,
    input  logic [DATA_W-1:0] m_dat_i,
    input  logic              m_ack_i,
    input  logic              m_err_i,
    output logic [1:0]        gnt_o
);

    arb_state_e state_r;

    logic       i_req_s;
    logic       d_req_s;
    logic       own_i_s;
    logic       own_d_s;
    logic       owner_cyc_s;
    logic       owner_stb_s;
    logic       tmo_hit_s;
    logic       term_s;
    logic [1:0] rr_req_s;
    logic [1:0] rr_gnt_s;
    logic       rr_adv_s;

    assign i_req_s = i_cyc_i & i_stb_i;
    assign d_req_s = d_cyc_i & d_stb_i;
    assign own_i_s = (state_r == ST_GNT_I);
    assign own_d_s = (state_r == ST_GNT_D);

    // cyc/stb of whichever master currently owns the bus.
    always_comb begin
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
        case (state_r)
            ST_GNT_I: begin
                owner_cyc_s = i_cyc_i;
                owner_stb_s = i_cyc_i & i_stb_i;
            end
            ST_GNT_D: begin
                owner_cyc_s = d_cyc_i;
                owner_stb_s = d_cyc_i & d_stb_i;
            end
            default: begin
                owner_cyc_s = 1'b0;
                owner_stb_s = 1'b0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_r;

    assign tmo_hit_s = owner_stb_s & (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES));

    // Stall counter: cleared whenever the grant changes (any termination or
    // abort, and continuously while idle), counts strobed unanswered cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (term_s | ~owner_cyc_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (owner_stb_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // A timed-out transfer is hidden from the slave for its final cycle so a
    // response arriving exactly then cannot be mistaken for a second one.
    assign m_cyc_o = owner_cyc_s & ~tmo_hit_s;
    assign m_stb_o = owner_stb_s & ~tmo_hit_s;

    assign term_s  = (m_stb_o & (m_ack_i | m_err_i)) | tmo_hit_s;

    // Request vector offered to the picker: everyone while idle, only the
    // waiting master at a termination (zero-bubble handover), else nothing.
    always_comb begin
        rr_req_s = 2'b00;
        case (state_r)
            ST_IDLE:  rr_req_s = {d_req_s, i_req_s};
            ST_GNT_I: rr_req_s = term_s ? {d_req_s, 1'b0} : 2'b00;
            ST_GNT_D: rr_req_s = term_s ? {1'b0, i_req_s} : 2'b00;
            default:  rr_req_s = 2'b00;
        endcase
    end

    // Any request reaching the picker is always granted, so that is the advance.
    assign rr_adv_s = |rr_req_s;

    riscv_wb_rr_arb u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (rr_req_s),
        .advance (rr_adv_s),
        .gnt     (rr_gnt_s)
    );

    // Arbiter FSM; termination takes priority over an owner abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rr_gnt_s[1]) begin
                        state_r <= ST_GNT_D;
                    end else if (rr_gnt_s[0]) begin
                        state_r <= ST_GNT_I;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GNT_I: begin
                    if (term_s) begin
                        state_r <= rr_gnt_s[1] ? ST_GNT_D : ST_IDLE;
                    end else if (!i_cyc_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_GNT_I;
                    end
                end
                ST_GNT_D: begin
                    if (term_s) begin
                        state_r <= rr_gnt_s[0] ? ST_GNT_I : ST_IDLE;
                    end else if (!d_cyc_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_GNT_D;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Shared-bus request mux and grant code, decoded from the registered state.
    always_comb begin
        m_we_o  = 1'b0;
        m_sel_o = 4'h0;
        m_adr_o = {ADDR_W{1'b0}};
        m_dat_o = {DATA_W{1'b0}};
        gnt_o   = GNT_NONE;
        case (state_r)
            ST_GNT_I: begin
                m_we_o  = 1'b0;
                m_sel_o = SEL_ALL;
                m_adr_o = i_adr_i;
                m_dat_o = {DATA_W{1'b0}};
                gnt_o   = GNT_I;
            end
            ST_GNT_D: begin
                m_we_o  = d_we_i;
                m_sel_o = d_sel_i;
                m_adr_o = d_adr_i;
                m_dat_o = d_dat_i;
                gnt_o   = GNT_D;
            end
            default: begin
                m_we_o  = 1'b0;
                m_sel_o = 4'h0;
                m_adr_o = {ADDR_W{1'b0}};
                m_dat_o = {DATA_W{1'b0}};
                gnt_o   = GNT_NONE;
            end
        endcase
    end

    // Responses go only to the owner; gating with m_stb_o drops stray
    // responses while idle or between strobes.
    assign i_ack_o = own_i_s & m_ack_i & m_stb_o;
    assign i_err_o = own_i_s & ((m_err_i & m_stb_o) | tmo_hit_s);
    assign d_ack_o = own_d_s & m_ack_i & m_stb_o;
    assign d_err_o = own_d_s & ((m_err_i & m_stb_o) | tmo_hit_s);

    assign i_dat_o = m_dat_i;
    assign d_dat_o = m_dat_i;

endmodule

// File: tb/tb_riscv_wb_arb.sv
// tb_riscv_wb_arb
// Self-checking bench for riscv_wb_arb: a behavioural slave pops expected
// transfers from a scoreboard queue as it answers them, master tasks check
// their own responses, and scenario tasks check grant sequencing.
// Build with WB_ARB_TIMEOUT_EN defined to exercise the stall timeout.
module tb_riscv_wb_arb;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        i_cyc, i_stb;
    logic [31:0] i_adr;
    logic [31:0] i_dat_o;
    logic        i_ack_o, i_err_o;
    logic        d_cyc, d_stb, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_adr, d_dat;
    logic [31:0] d_dat_o;
    logic        d_ack_o, d_err_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i, m_err_i;
    logic [1:0]  gnt_o;

    always #5 clk = ~clk;

    riscv_wb_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .i_cyc_i(i_cyc), .i_stb_i(i_stb), .i_adr_i(i_adr),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
        .d_cyc_i(d_cyc), .d_stb_i(d_stb), .d_we_i(d_we), .d_sel_i(d_sel),
        .d_adr_i(d_adr), .d_dat_i(d_dat),
        .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .gnt_o(gnt_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } xfer_t;

    xfer_t sb_q[$];

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return a ^ 32'h3C3C_5A5A;
    endfunction

    // Slave controls
    int slv_lat    = 0;
    bit slv_err    = 1'b0;
    bit slv_mute   = 1'b0;
    bit slv_inject = 1'b0;

    // Behavioural slave: answers slv_lat cycles after the strobe is seen and
    // checks each answered transfer against the scoreboard.
    initial begin
        int    wait_cnt;
        xfer_t exp_x;
        xfer_t act_x;
        wait_cnt = 0;
        m_ack_i  = 1'b0;
        m_err_i  = 1'b0;
        m_dat_i  = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            m_ack_i = 1'b0;
            m_err_i = 1'b0;
            m_dat_i = 32'h0;
            if (slv_inject) begin
                m_ack_i = 1'b1;
            end else if (m_cyc_o && m_stb_o && !slv_mute) begin
                if (wait_cnt >= slv_lat) begin
                    wait_cnt = 0;
                    if (slv_err) begin
                        m_err_i = 1'b1;
                    end else begin
                        m_ack_i = 1'b1;
                        m_dat_i = rd_pat(m_adr_o);
                    end
                    total++;
                    act_x = xfer_t'{gnt_o, m_adr_o, m_we_o, m_sel_o, m_dat_o};
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: got gnt=%b adr=%h, nothing expected", gnt_o, m_adr_o);
                    end else begin
                        exp_x = sb_q.pop_front();
                        if (act_x !== exp_x) begin
                            bad++;
                            $display("FAIL sb_xfer: got gnt=%b adr=%h we=%b sel=%h dat=%h, want gnt=%b adr=%h we=%b sel=%h dat=%h",
                                     act_x.gnt, act_x.adr, act_x.we, act_x.sel, act_x.dat,
                                     exp_x.gnt, exp_x.adr, exp_x.we, exp_x.sel, exp_x.dat);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Response and grant monitor
    int i_ack_cnt = 0, d_ack_cnt = 0, i_err_cnt = 0, d_err_cnt = 0;
    bit log_en = 1'b0;
    logic [1:0] gnt_log[$];

    always @(negedge clk) begin
        if (i_ack_o) i_ack_cnt++;
        if (d_ack_o) d_ack_cnt++;
        if (i_err_o) i_err_cnt++;
        if (d_err_o) d_err_cnt++;
        if (log_en) gnt_log.push_back(gnt_o);
    end

    // Grant history as a list of distinct owners (leading/trailing idle removed).
    function automatic void compress_log(output logic [31:0] v, output int n);
        logic [1:0] last;
        v    = 32'h0;
        n    = 0;
        last = 2'b00;
        foreach (gnt_log[k]) begin
            if (gnt_log[k] !== last) begin
                v    = (v << 2) | {30'h0, gnt_log[k]};
                n++;
                last = gnt_log[k];
            end
        end
        if (n > 0 && v[1:0] == 2'b00) begin
            v = v >> 2;
            n--;
        end
    endfunction

    // Master tasks: called at posedge+2, return at posedge+2 after the response.
    task automatic i_xfer(input logic [31:0] adr, input bit keep, output bit got_err);
        bit done;
        done    = 1'b0;
        got_err = 1'b0;
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = adr;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (i_ack_o || i_err_o) begin
                done    = 1'b1;
                got_err = i_err_o;
                if (i_ack_o) begin
                    total++;
                    if (i_dat_o !== rd_pat(adr)) begin
                        bad++;
                        $display("FAIL i_rdata: got %h want %h", i_dat_o, rd_pat(adr));
                    end
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL i_xfer_timeout: adr=%h got no response, want ack/err", adr);
        end
        @(posedge clk); #2;
        if (!keep) begin i_cyc = 1'b0; i_stb = 1'b0; end
    endtask

    task automatic d_xfer(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                          input logic [31:0] dat, input bit keep, output bit got_err);
        bit done;
        done    = 1'b0;
        got_err = 1'b0;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = adr; d_we = we; d_sel = sel; d_dat = dat;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (d_ack_o || d_err_o) begin
                done    = 1'b1;
                got_err = d_err_o;
                if (d_ack_o && !we) begin
                    total++;
                    if (d_dat_o !== rd_pat(adr)) begin
                        bad++;
                        $display("FAIL d_rdata: got %h want %h", d_dat_o, rd_pat(adr));
                    end
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL d_xfer_timeout: adr=%h got no response, want ack/err", adr);
        end
        @(posedge clk); #2;
        if (!keep) begin d_cyc = 1'b0; d_stb = 1'b0; end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_ni = 1'b0;
        @(posedge clk); #2;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h40;
        d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h80;
        repeat (3) @(negedge clk);
        total++;
        if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        total++;
        if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
            bad++; $display("FAIL reset_cyc_stb: got %b%b want 00", m_cyc_o, m_stb_o);
        end
        total++;
        if (m_adr_o !== 32'h0) begin bad++; $display("FAIL reset_adr: got %h want 0", m_adr_o); end
        @(posedge clk); #2;
        i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic test_i_fetch();
        int ia0, da0;
        bit e;
        do_reset();
        slv_lat = 2; slv_err = 1'b0; slv_mute = 1'b0;
        ia0 = i_ack_cnt; da0 = d_ack_cnt;
        sb_q.push_back(xfer_t'{2'b01, 32'h100, 1'b0, 4'hF, 32'h0});
        fork
            i_xfer(32'h100, 1'b0, e);
            begin
                @(negedge clk);
                total++;
                if (m_cyc_o !== 1'b0) begin bad++; $display("FAIL latency_pre: m_cyc got %b want 0", m_cyc_o); end
                @(negedge clk);
                total++;
                if (gnt_o !== 2'b01 || m_cyc_o !== 1'b1 || m_stb_o !== 1'b1) begin
                    bad++; $display("FAIL latency_grant: gnt/cyc/stb got %b/%b/%b want 01/1/1", gnt_o, m_cyc_o, m_stb_o);
                end
            end
        join
        total++;
        if (i_ack_cnt - ia0 !== 1) begin bad++; $display("FAIL i_ack_pulse: got %0d ack cycles want 1", i_ack_cnt - ia0); end
        total++;
        if (d_ack_cnt !== da0) begin bad++; $display("FAIL d_ack_quiet: got %0d want %0d", d_ack_cnt, da0); end
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b00) begin bad++; $display("FAIL i_release: gnt got %b want 00", gnt_o); end
    endtask

    task automatic test_simultaneous();
        bit e1, e2;
        logic [31:0] v;
        int n;
        do_reset();
        slv_lat = 1;
        sb_q.push_back(xfer_t'{2'b10, 32'h8000, 1'b1, 4'h3, 32'hA5A5A5A5});
        sb_q.push_back(xfer_t'{2'b01, 32'h200, 1'b0, 4'hF, 32'h0});
        gnt_log.delete();
        log_en = 1'b1;
        fork
            d_xfer(32'h8000, 1'b1, 4'h3, 32'hA5A5A5A5, 1'b0, e1);
            i_xfer(32'h200, 1'b0, e2);
        join
        repeat (2) @(negedge clk);
        log_en = 1'b0;
        compress_log(v, n);
        total++;
        if (n !== 2 || v !== 32'h9) begin
            bad++; $display("FAIL handover_seq: got %0d owners code %h want 2 owners code 9 (D then I, no idle)", n, v);
        end
    endtask

    task automatic test_back_to_back();
        bit e;
        logic [31:0] v;
        int n;
        do_reset();
        slv_lat = 0;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back(xfer_t'{2'b10, 32'h10 + 32'(4*k), 1'b1, 4'hF, 32'hD000_0000 + 32'(k)});
            sb_q.push_back(xfer_t'{2'b01, 32'h400 + 32'(4*k), 1'b0, 4'hF, 32'h0});
        end
        gnt_log.delete();
        log_en = 1'b1;
        fork
            begin
                d_xfer(32'h10, 1'b1, 4'hF, 32'hD000_0000, 1'b1, e);
                d_xfer(32'h14, 1'b1, 4'hF, 32'hD000_0001, 1'b1, e);
                d_xfer(32'h18, 1'b1, 4'hF, 32'hD000_0002, 1'b0, e);
            end
            begin
                i_xfer(32'h400, 1'b1, e);
                i_xfer(32'h404, 1'b1, e);
                i_xfer(32'h408, 1'b0, e);
            end
        join
        repeat (2) @(negedge clk);
        log_en = 1'b0;
        compress_log(v, n);
        total++;
        if (n !== 6 || v !== 32'h999) begin
            bad++; $display("FAIL alternate_seq: got %0d owners code %h want 6 owners code 999 (D,I,D,I,D,I)", n, v);
        end
    endtask

    task automatic test_abort();
        int ia0, da0;
        do_reset();
        slv_mute = 1'b1;
        ia0 = i_ack_cnt; da0 = d_ack_cnt;
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_adr = 32'h3000; d_dat = 32'h0;
        repeat (2) @(negedge clk);
        total++;
        if (gnt_o !== 2'b10) begin bad++; $display("FAIL abort_grant: got %b want 10", gnt_o); end
        @(posedge clk); #2;
        d_cyc = 1'b0; d_stb = 1'b0;
        @(negedge clk);
        total++;
        if (m_cyc_o !== 1'b0) begin bad++; $display("FAIL abort_cyc: got %b want 0", m_cyc_o); end
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b00) begin bad++; $display("FAIL abort_idle: gnt got %b want 00", gnt_o); end
        @(posedge clk); #1;
        slv_inject = 1'b1;
        @(negedge clk);
        total++;
        if (i_ack_o !== 1'b0 || d_ack_o !== 1'b0) begin
            bad++; $display("FAIL late_ack: i/d ack got %b/%b want 0/0", i_ack_o, d_ack_o);
        end
        slv_inject = 1'b0;
        @(negedge clk);
        total++;
        if (i_ack_cnt !== ia0 || d_ack_cnt !== da0 || gnt_o !== 2'b00) begin
            bad++; $display("FAIL late_ack_cnt: acks %0d/%0d gnt %b want %0d/%0d gnt 00", i_ack_cnt, d_ack_cnt, gnt_o, ia0, da0);
        end
        slv_mute = 1'b0;
    endtask

    task automatic test_error();
        int da0, de0;
        bit e;
        do_reset();
        slv_lat = 1; slv_err = 1'b1;
        da0 = d_ack_cnt; de0 = d_err_cnt;
        sb_q.push_back(xfer_t'{2'b10, 32'hFFFF0000, 1'b0, 4'hF, 32'h0});
        d_xfer(32'hFFFF0000, 1'b0, 4'hF, 32'h0, 1'b0, e);
        total++;
        if (e !== 1'b1 || d_err_cnt - de0 !== 1) begin
            bad++; $display("FAIL d_err_pulse: got err=%b cycles=%0d want err=1 cycles=1", e, d_err_cnt - de0);
        end
        total++;
        if (d_ack_cnt !== da0) begin bad++; $display("FAIL d_err_noack: got %0d acks want %0d", d_ack_cnt, da0); end
        @(negedge clk);
        total++;
        if (gnt_o !== 2'b00) begin bad++; $display("FAIL err_release: gnt got %b want 00", gnt_o); end
        slv_err = 1'b0;
    endtask

    task automatic test_timeout();
        int k;
        int hi;
        bit found;
        do_reset();
        slv_mute = 1'b1;
        k = 0; hi = 0; found = 1'b0;
        i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h500;
`ifdef WB_ARB_TIMEOUT_EN
        for (int n = 1; n <= 20 && !found; n++) begin
            @(negedge clk);
            if (i_err_o) begin
                found = 1'b1;
                k = n;
                total++;
                if (m_cyc_o !== 1'b0) begin bad++; $display("FAIL tmo_cyc: got %b want 0", m_cyc_o); end
            end
        end
        total++;
        if (k !== 6) begin bad++; $display("FAIL tmo_cycle: err at sample %0d want 6", k); end
        @(posedge clk); #2;
        i_cyc = 1'b0; i_stb = 1'b0;
`else
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_cyc_o) hi++;
        end
        total++;
        if (hi !== 100) begin bad++; $display("FAIL stall_hold: cyc high %0d cycles want 100", hi); end
        @(posedge clk); #2;
        i_cyc = 1'b0; i_stb = 1'b0;
        found = 1'b1;
`endif
        repeat (2) @(negedge clk);
        total++;
        if (gnt_o !== 2'b00 || !found) begin bad++; $display("FAIL tmo_release: gnt got %b want 00", gnt_o); end
        slv_mute = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        slv_mute = 1'b1;
        d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_sel = 4'h1; d_adr = 32'h600; d_dat = 32'h11;
        repeat (2) @(negedge clk);
        total++;
        if (m_cyc_o !== 1'b1) begin bad++; $display("FAIL mid_pre: m_cyc got %b want 1", m_cyc_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if (m_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin
            bad++; $display("FAIL mid_reset: cyc/gnt got %b/%b want 0/00", m_cyc_o, gnt_o);
        end
        d_cyc = 1'b0; d_stb = 1'b0;
        @(posedge clk); #2;
        rst_ni = 1'b1;
        slv_mute = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        i_cyc = 1'b0; i_stb = 1'b0; i_adr = 32'h0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_sel = 4'h0; d_adr = 32'h0; d_dat = 32'h0;
        test_reset();
        test_i_fetch();
        test_simultaneous();
        test_back_to_back();
        test_abort();
        test_error();
        test_timeout();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: %0d transfers never seen, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_wb_arb.md
Name: riscv_wb_arb

Overview:
Two-master to one-slave Wishbone B3 classic arbiter. It shares a single external Wishbone master port between the core's instruction bus (iwb) and data bus (dwb). It sits between the core's bus-interface unit and the SoC interconnect, so single-port memories and peripherals can serve both fetch and load/store. Arbitration is round-robin per transfer, and the grant is held until the transfer terminates.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYCLES, 255, stall cycles before forced error (used only with WB_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
i_cyc_i  in  1  instruction master cycle
i_stb_i  in  1  instruction master strobe
i_adr_i  in  ADDR_W  instruction address
i_dat_o  out  DATA_W  instruction read data
i_ack_o  out  1  instruction ack
i_err_o  out  1  instruction error
d_cyc_i  in  1  data master cycle
d_stb_i  in  1  data master strobe
d_we_i  in  1  data write enable
d_sel_i  in  4  data byte selects
d_adr_i  in  ADDR_W  data address
d_dat_i  in  DATA_W  data write data
d_dat_o  out  DATA_W  data read data
d_ack_o  out  1  data ack
d_err_o  out  1  data error
m_cyc_o  out  1  shared bus cycle
m_stb_o  out  1  shared bus strobe
m_we_o  out  1  shared bus write enable
m_sel_o  out  4  shared bus byte selects
m_adr_o  out  ADDR_W  shared bus address
m_dat_o  out  DATA_W  shared bus write data
m_dat_i  in  DATA_W  shared bus read data
m_ack_i  in  1  shared bus ack
m_err_i  in  1  shared bus error
gnt_o  out  2  current grant: 00 none, 01 I, 10 D

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, gnt_o=00, priority pointer favours D, timeout counter=0.
- Outputs depend combinationally on the registered state, so every output is 0 during reset.
- States: IDLE, GNT_I, GNT_D.
- IDLE: a request is cyc&stb.
  - Only one requester active: move to that requester's grant next edge.
  - Both active: grant the requester the pointer favours.
  - Update the pointer to favour the other requester.
- First-access latency: request seen at edge N, grant registered at N, m_cyc_o/m_stb_o high from cycle N+1.
- While in GNT_x:
  - m_cyc_o = x_cyc, m_stb_o = x_cyc & x_stb.
  - m_adr_o, m_we_o, m_sel_o, m_dat_o muxed from owner x.
  - I owner: m_we_o=0, m_sel_o=4'hF, m_dat_o=0.
- Responses:
  - Owner gets x_ack_o = m_ack_i & m_stb_o and x_err_o = m_err_i & m_stb_o, combinationally.
  - Non-owner ack/err are 0.
  - m_dat_i drives both i_dat_o and d_dat_o.
- In IDLE all m_* outputs are 0, and any m_ack_i/m_err_i is ignored.
- Termination: at the edge where m_ack_i or m_err_i is seen with m_stb_o high:
  - If the other requester has cyc&stb, go directly to its grant (zero-bubble handover) and update the pointer.
  - Else go to IDLE.
  - The same owner never receives two consecutive grants while the other waits.
- Owner abort: owner drops cyc before ack → return to IDLE next edge. A late ack in IDLE is dropped.
- Simultaneous termination and abort → treated as termination.
- Reset mid-transfer: grant is lost immediately and m_cyc_o falls asynchronously. The slave must tolerate this.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: an 8..16-bit counter, sized by TIMEOUT_CYCLES, clears on every grant change and increments each cycle with m_stb_o high and no ack/err.
  - When it equals TIMEOUT_CYCLES, the owner gets x_err_o=1 for that cycle.
  - m_cyc_o/m_stb_o are forced 0 that cycle, and the FSM terminates as on m_err_i.
- Undefined: no counter; a stalled slave holds the grant indefinitely.

Decomposition:
- Package riscv_wb_pkg: state encoding (IDLE/GNT_I/GNT_D), grant codes (GNT_NONE=2'b00, GNT_I=2'b01, GNT_D=2'b10), SEL_ALL=4'hF.
- One natural sub-module: riscv_wb_rr_arb. It is a 2-input round-robin picker: req[1:0], pointer register, one-hot grant, and an advance input.

Test Plan:
- I-only fetch at 0x100, slave acks 2 cycles after stb → m_adr_o=0x100, m_sel_o=F, m_we_o=0; i_ack_o is a 1-cycle pulse; d_ack_o stays 0; gnt_o 01→00.
- Simultaneous I(0x200) and D write(0x8000, sel=3, data 0xA5A5A5A5) out of reset → D granted first (gnt_o=10). After D ack, handover to I with no idle cycle between.
- Both requesters held continuously for 6 transfers → grants alternate D,I,D,I,D,I.
- D owner drops cyc before ack → FSM IDLE next cycle; an injected late ack produces neither i_ack_o nor d_ack_o.
- m_err_i on a D read at 0xFFFF0000 → d_err_o pulses, d_ack_o=0, grant released.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks → i_err_o pulses after 4 stalled cycles and m_cyc_o drops. Without the macro, m_cyc_o stays high for 100 cycles.
